// File: rtl/iir_sos_if.sv
`default_nettype none
// ============================================================================
// Module  : iir_sos_if
// Brief   : Sample-stream and shared-biquad job bus for iir_sos_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface iir_sos_if #(
    parameter int DW    = 24,
    parameter int SEC_W = 2
);
    logic [DW-1:0]    data_in;
    logic             valid_in;
    logic             dp_start;
    logic [SEC_W-1:0] dp_sec;
    logic [DW-1:0]    dp_x;
    logic             dp_done;
    logic [DW-1:0]    dp_y;
    logic [DW-1:0]    data_out;
    logic             valid_out;

    modport master (
        input  data_in, valid_in, dp_done, dp_y,
        output dp_start, dp_sec, dp_x, data_out, valid_out
    );

    modport slave (
        output data_in, valid_in, dp_done, dp_y,
        input  dp_start, dp_sec, dp_x, data_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/iir_sos_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : iir_sos_scheduler
// Brief   : Time-multiplexes one biquad datapath over NSEC cascaded sections.
//           Optional macro IIR_SCHED_HOLD_EN adds a one-entry sample hold.
// Revision: 1.0 - initial release
// ============================================================================
module iir_sos_scheduler #(
    parameter int DW    = 24,
    parameter int NSEC  = 4,
    parameter int SEC_W = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    iir_sos_if.master bus,
    input  logic      clr_ovr,
    output logic      busy,
    output logic      overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_xreg;
    logic [DW-1:0]    w_xreg_nxt;
    logic [SEC_W-1:0] r_sec;
    logic [SEC_W-1:0] w_sec_nxt;
    logic             w_drop;

    logic             r_dp_start;
    logic [SEC_W-1:0] r_dp_sec;
    logic [DW-1:0]    r_dp_x;
    logic [DW-1:0]    r_data_out;
    logic             r_valid_out;
    logic             r_busy;
    logic             r_overrun;

`ifdef IIR_SCHED_HOLD_EN
    logic [DW-1:0]    r_hold;
    logic [DW-1:0]    w_hold_nxt;
    logic             r_hold_full;
    logic             w_hold_full_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xreg_nxt  = r_xreg;
        w_sec_nxt   = r_sec;
        w_drop      = 1'b0;
`ifdef IIR_SCHED_HOLD_EN
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.valid_in) begin
                    w_xreg_nxt  = bus.data_in;
                    w_sec_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.dp_done) begin
                    w_xreg_nxt = bus.dp_y;
                    if (r_sec == SEC_W'(NSEC - 1)) begin
                        w_state_nxt = S_OUT;
                    end else begin
                        w_sec_nxt   = r_sec + SEC_W'(1);
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_OUT: begin
                w_state_nxt = S_IDLE;
`ifdef IIR_SCHED_HOLD_EN
                if (r_hold_full) begin
                    // Held sample starts immediately; a new arrival refills the hold.
                    w_xreg_nxt      = r_hold;
                    w_sec_nxt       = '0;
                    w_state_nxt     = S_ISSUE;
                    w_hold_full_nxt = bus.valid_in;
                    if (bus.valid_in) begin
                        w_hold_nxt = bus.data_in;
                    end
                end else if (bus.valid_in) begin
                    w_xreg_nxt  = bus.data_in;
                    w_sec_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
`else
                if (bus.valid_in) begin
                    w_xreg_nxt  = bus.data_in;
                    w_sec_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if ((r_state == S_ISSUE || r_state == S_WAIT) && bus.valid_in) begin
`ifdef IIR_SCHED_HOLD_EN
            if (!r_hold_full) begin
                w_hold_nxt      = bus.data_in;
                w_hold_full_nxt = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
`else
            w_drop = 1'b1;
`endif
        end
    end

    // Job-bus and output registers are loaded on entry to their state so they
    // are valid throughout the ISSUE/OUT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xreg      <= '0;
            r_sec       <= '0;
            r_dp_start  <= 1'b0;
            r_dp_sec    <= '0;
            r_dp_x      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_xreg      <= w_xreg_nxt;
            r_sec       <= w_sec_nxt;
            r_dp_start  <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_ISSUE) begin
                r_dp_sec <= w_sec_nxt;
                r_dp_x   <= w_xreg_nxt;
            end
            r_valid_out <= (w_state_nxt == S_OUT);
            if (w_state_nxt == S_OUT) begin
                r_data_out <= w_xreg_nxt;
            end
            r_busy      <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef IIR_SCHED_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end
`endif

    assign bus.dp_start  = r_dp_start;
    assign bus.dp_sec    = r_dp_sec;
    assign bus.dp_x      = r_dp_x;
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign busy          = r_busy;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_iir_sos_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_iir_sos_scheduler
// Brief   : Directed self-checking bench for iir_sos_scheduler with a
//           latency-1 datapath model. Honours IIR_SCHED_HOLD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iir_sos_scheduler;

    localparam int DW    = 24;
    localparam int NSEC  = 4;
    localparam int SEC_W = 2;
`ifdef IIR_SCHED_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic clr_ovr = 1'b0;
    logic busy;
    logic overrun;

    iir_sos_if #(.DW(DW), .SEC_W(SEC_W)) bus ();

    iir_sos_scheduler #(.DW(DW), .NSEC(NSEC), .SEC_W(SEC_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clr_ovr (clr_ovr),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    int            vouts    = 0;
    int            dp_mode  = 0;
    logic          spur_req = 1'b0;
    logic [DW-1:0] spur_y   = '0;
    logic          pend     = 1'b0;
    logic [DW-1:0] pend_y   = '0;
    logic [DW-1:0] rnd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Datapath model: dp_done one cycle after dp_start (L=1), y = x+1 or -x
    initial begin
        bus.dp_done = 1'b0;
        bus.dp_y    = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.dp_done = pend | spur_req;
            bus.dp_y    = spur_req ? spur_y : pend_y;
            spur_req    = 1'b0;
            pend        = bus.dp_start;
            pend_y      = (dp_mode == 0) ? bus.dp_x + DW'(1) : -bus.dp_x;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.data_in  = d;
        bus.valid_in = 1'b1;
        cyc          = 0;
        step();
        bus.valid_in = 1'b0;
    endtask

    task automatic run_job(input logic [DW-1:0] din, input logic [DW-1:0] exp, input string tag);
        int early = 0;
        send(din);
        while (cyc < 9) begin
            if (bus.valid_out) early++;
            step();
        end
        check({tag, "_early_vout"}, early, 0);
        check({tag, "_vout"}, 32'(bus.valid_out), 32'h1);
        check({tag, "_dout"}, 32'(bus.data_out), 32'(exp));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dp_start"},  32'(bus.dp_start),  32'h0);
        check({tag, "_dp_sec"},    32'(bus.dp_sec),    32'h0);
        check({tag, "_dp_x"},      32'(bus.dp_x),      32'h0);
        check({tag, "_data_out"},  32'(bus.data_out),  32'h0);
        check({tag, "_valid_out"}, 32'(bus.valid_out), 32'h0);
        check({tag, "_busy"},      32'(busy),          32'h0);
        check({tag, "_overrun"},   32'(overrun),       32'h0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // Single sample through four y=x+1 sections
        send(24'h000100);
        while (cyc <= 9) begin
            check("t1_start", 32'(bus.dp_start), 32'(cyc % 2 == 1 && cyc <= 7));
            if (bus.dp_start) begin
                check("t1_sec", 32'(bus.dp_sec), (cyc - 1) / 2);
                check("t1_x",   32'(bus.dp_x),   32'h100 + (cyc - 1) / 2);
            end
            check("t1_vout", 32'(bus.valid_out), 32'(cyc == 9));
            check("t1_busy", 32'(busy), 32'(cyc >= 1 && cyc <= 8));
            if (cyc == 9) check("t1_dout", 32'(bus.data_out), 32'h000104);
            step();
        end

        // Sustained 10-cycle stream with y=-x: even NSEC returns the input
        dp_mode = 1;
        for (int i = 0; i < 2048; i++) begin
            rnd = DW'($urandom);
            run_job(rnd, rnd, "t2");
            step();
        end
        check("t2_ovr", 32'(overrun), 32'h0);
        dp_mode = 0;

        // Second sample arrives at cycle 4 of a job
        vouts = 0;
        send(24'h000200);
        while (cyc < 25) begin
            bus.valid_in = (cyc == 4);
            bus.data_in  = 24'h000300;
            step();
            if (cyc == 5) check("t3_ovr", 32'(overrun), 32'(!HOLD));
`ifdef IIR_SCHED_HOLD_EN
            if (cyc == 10) begin
                check("t3_start2", 32'(bus.dp_start), 32'h1);
                check("t3_sec2",   32'(bus.dp_sec),   32'h0);
                check("t3_x2",     32'(bus.dp_x),     32'h000300);
            end
`endif
            if (bus.valid_out) begin
                vouts++;
                if (vouts == 1) begin
                    check("t3_vout1_cyc", cyc, 9);
                    check("t3_dout1", 32'(bus.data_out), 32'h000204);
                end else begin
                    check("t3_vout2_cyc", cyc, 18);
                    check("t3_dout2", 32'(bus.data_out), 32'h000304);
                end
            end
        end
        bus.valid_in = 1'b0;
        check("t3_nvout", vouts, HOLD ? 2 : 1);

        // Overrun clear: set wins over simultaneous clear
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("t4_clr_idle", 32'(overrun), 32'h0);
        send(24'h000400);
        while (cyc < 30) begin
            bus.valid_in = (cyc == 2 || cyc == 4);
            bus.data_in  = 24'h000500;
            clr_ovr      = (cyc == 4 || cyc == 5);
            step();
            if (cyc == 5) check("t4_set_wins", 32'(overrun), 32'h1);
            if (cyc == 6) check("t4_clr", 32'(overrun), 32'h0);
        end
        bus.valid_in = 1'b0;
        clr_ovr      = 1'b0;

        // Asynchronous reset in cycle 5 of a job
        send(24'h000600);
        while (cyc < 5) step();
        check("t5_pre_sec", 32'(bus.dp_sec), 32'h2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_rst");
        vouts = 0;
        repeat (3) begin
            step();
            if (bus.valid_out) vouts++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            step();
            if (bus.valid_out) vouts++;
        end
        check("t5_no_vout", vouts, 0);
        run_job(24'h000700, 24'h000704, "t5");
        step();

        // Spurious dp_done in IDLE, then in ISSUE
        spur_y   = 24'hABCDEF;
        spur_req = 1'b1;
        step();
        send(24'h000800);
        spur_y   = 24'h123456;
        spur_req = 1'b1;
        vouts    = 0;
        while (cyc < 9) begin
            if (bus.valid_out) vouts++;
            if (cyc == 3) begin
                check("t6_sec1", 32'(bus.dp_sec), 32'h1);
                check("t6_x1",   32'(bus.dp_x),   32'h000801);
            end
            step();
        end
        check("t6_early_vout", vouts, 0);
        check("t6_vout", 32'(bus.valid_out), 32'h1);
        check("t6_dout", 32'(bus.data_out), 32'h000804);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iir_sos_scheduler.md
# iir_sos_scheduler

Sequencer that time-multiplexes one shared biquad (second-order-section) datapath across `NSEC` cascaded IIR stages. It sits between the sample-rate input interface (one-cycle `valid_in` pulse per sample, nominally every 10 clocks at 150 MHz) and the output interface of `opti_top`. For each accepted sample it issues one datapath job per section, chains each section's result into the next, and emits the final section output with a one-cycle `valid_out`.

## Interface
- `DW`, 24, sample width, two's complement
- `NSEC`, 4, number of cascaded sections (≥1)
- `SEC_W`, 2, width of section index; must be ≥ clog2(`NSEC`), and ≥1
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data_in`  in  DW  input sample
- `valid_in`  in  1  one-cycle sample strobe
- `dp_start`  out  1  one-cycle job start to the shared datapath
- `dp_sec`  out  SEC_W  section index for coefficients/state select; held stable from `dp_start` until `dp_done`
- `dp_x`  out  DW  section input sample; held stable like `dp_sec`
- `dp_done`  in  1  one-cycle job completion from the datapath
- `dp_y`  in  DW  section result; valid only while `dp_done`=1
- `data_out`  out  DW  final filtered sample; held between outputs
- `valid_out`  out  1  one-cycle output strobe
- `busy`  out  1  high in ISSUE and WAIT
- `overrun`  out  1  sticky: a sample was dropped
- `clr_ovr`  in  1  clears `overrun`

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: on `valid_in`, capture `data_in` into `xreg` and set `sec`=0. Go to ISSUE.
- ISSUE: assert `dp_start` for one cycle with `dp_sec`=`sec` and `dp_x`=`xreg`. Go to WAIT.
- WAIT: hold outputs until `dp_done`. On `dp_done`, load `dp_y` into `xreg`.
  - If `sec`=`NSEC`-1, go to OUT.
  - Otherwise increment `sec` and go to ISSUE.
- OUT: register `data_out`=`xreg` and pulse `valid_out`. Go to IDLE.
  - `valid_in` in OUT is accepted exactly as in IDLE and goes to ISSUE.
  - With a pending held sample, see Configuration.
- `dp_done` outside WAIT is ignored.
- `dp_y` passes through unmodified; no saturation in this block.
- `valid_in` in ISSUE or WAIT is dropped and sets `overrun` (unless Configuration applies).
- `overrun` set and `clr_ovr` in the same cycle: set wins.
- `sec` never exceeds `NSEC`-1; there is no wrap except the reset to 0 on a new sample.

## Timing
- Reset values: `dp_start`=0, `dp_sec`=0, `dp_x`=0, `data_out`=0, `valid_out`=0, `busy`=0, `overrun`=0, state=IDLE.
- Asserting `rst_n` mid-job aborts immediately. No `valid_out` is produced for the in-flight sample.
- Cycle numbering: `valid_in` is sampled in cycle 0. ISSUE for section k occurs in cycle 1+k(L+1), where L≥1 is the datapath latency (`dp_done` arrives L cycles after `dp_start`).
- `valid_out` occurs in cycle NSEC·(L+1)+1. With NSEC=4 and L=1, that is cycle 9.
- Back-to-back sustainable input period is NSEC·(L+1)+1 cycles.
- `busy` is registered with the state: high from the cycle after acceptance through the cycle of the last `dp_done`.
- `data_out` is updated only in the OUT cycle.

## Configuration
- `IIR_SCHED_HOLD_EN` defined: adds a one-entry hold register.
  - `valid_in` in ISSUE/WAIT with hold empty: capture into hold and set hold_full. `overrun` is not set.
  - OUT with hold_full: load hold into `xreg`, set `sec`=0, go directly to ISSUE, clear hold_full.
  - `valid_in` in that same OUT cycle: write the new sample into hold; hold stays full.
  - `valid_in` while hold_full in ISSUE/WAIT: dropped, `overrun` set.
  - Reset clears hold_full.
- `IIR_SCHED_HOLD_EN` undefined: no hold register; every `valid_in` in ISSUE/WAIT is dropped and sets `overrun`.

## Test plan
- Reset, then `valid_in` with `data_in`=0x000100, NSEC=4, datapath model y=x+1, L=1:
  - `dp_start` in cycles 1, 3, 5, 7 with `dp_sec`=0..3 and `dp_x`=0x100..0x103.
  - `valid_out` in cycle 9 with `data_out`=0x000104.
- 2048 samples at 10-cycle spacing (model y=−x): every `valid_out` equals the input for even NSEC, and `overrun` stays 0.
- Second `valid_in` at cycle 4 after the first:
  - Undefined macro: `overrun`=1 at cycle 5 and only one `valid_out`.
  - Defined macro: second job's ISSUE in cycle 10, second `valid_out` in cycle 18, `overrun`=0.
- `rst_n` low in cycle 5 of a job: all outputs return to reset values and there is no `valid_out`. The next sample then completes normally in 9 cycles.
- Spurious `dp_done` in IDLE and in ISSUE: `sec` and `xreg` are unchanged and the result is correct.
- `clr_ovr` pulsed in the same cycle as a drop: `overrun` stays 1. `clr_ovr` alone then clears it to 0.
